pixel_fetch: RTL and testbench

Framebuffer read stage between the HDMI timing generator and the processor's pixel memory. Tracks the raster from the incoming sync/DE strobes, issues `parallelAddress` reads into the processor's display memory, absorbs the memory read latency, and returns delay-aligned syncs plus 24-bit RGB expanded from the 8-bit `q` sample. An 8-bit `offset` is not used; `offset[17:0]` selects the image base and is sampled once per frame.

---
 rtl/pixel_fetch_if.sv | 30 +++
 rtl/pixel_fetch.sv | 161 ++++++++++++++++
 tb/tb_pixel_fetch.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pixel_fetch_if.sv
// pixel_fetch_if: bundle of the raster, memory and pixel-output signals of
// pixel_fetch.
//   slave  : the fetch stage (takes syncs/offset/q, drives address and pixels)
//   master : the environment (timing generator + pixel memory + sink)
// Signals: vs_in/hs_in/de_in raster strobes, offset[17:0] image base,
// q[7:0] memory sample, parallelAddress[23:0] memory read address,
// vs_out/hs_out/de_out delayed syncs, rgb_out[23:0] pixel, frame_done pulse.
interface pixel_fetch_if;
    logic        vs_in;
    logic        hs_in;
    logic        de_in;
    logic [17:0] offset;
    logic [7:0]  q;
    logic [23:0] parallelAddress;
    logic        vs_out;
    logic        hs_out;
    logic        de_out;
    logic [23:0] rgb_out;
    logic        frame_done;

    modport slave (
        input  vs_in, hs_in, de_in, offset, q,
        output parallelAddress, vs_out, hs_out, de_out, rgb_out, frame_done
    );

    modport master (
        output vs_in, hs_in, de_in, offset, q,
        input  parallelAddress, vs_out, hs_out, de_out, rgb_out, frame_done
    );
endinterface

// File: rtl/pixel_fetch.sv
// pixel_fetch: framebuffer read stage. Follows the raster from vs/hs/de,
// reads the image window out of pixel memory and returns delay-aligned
// syncs with gray samples expanded to RGB.
//   clk : pixel clock
//   rst : asynchronous active-high reset
//   bus : pixel_fetch_if.slave (strobes, offset, q in; address, pixels out)
// Optional build macro PIXEL_FETCH_ZOOM2X_EN: each source pixel covers a
// 2x2 screen block (window becomes 2*IMG_W x 2*IMG_H).
// Pixel latency is RAM_LAT+2: one cycle to register the address, RAM_LAT
// cycles of memory, one output register.
module pixel_fetch #(
    parameter int         H_ACTIVE = 640,
    parameter int         V_ACTIVE = 480,
    parameter int         IMG_W    = 256,
    parameter int         IMG_H    = 256,
    parameter int         IMG_X0   = 192,
    parameter int         IMG_Y0   = 112,
    parameter int         RAM_LAT  = 2,
    parameter logic [7:0] BORDER   = 8'h00
) (
    input  logic         clk,
    input  logic         rst,
    pixel_fetch_if.slave bus
);
`ifdef PIXEL_FETCH_ZOOM2X_EN
    localparam int W_EFF = 2 * IMG_W;
    localparam int H_EFF = 2 * IMG_H;
`else
    localparam int W_EFF = IMG_W;
    localparam int H_EFF = IMG_H;
`endif
    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam logic [XW-1:0] X_LO   = XW'(IMG_X0);
    localparam logic [XW-1:0] X_HI   = XW'(IMG_X0 + W_EFF);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_X0 + W_EFF - 1);
    localparam logic [XW-1:0] X_MAX  = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LO   = YW'(IMG_Y0);
    localparam logic [YW-1:0] Y_HI   = YW'(IMG_Y0 + H_EFF);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_Y0 + H_EFF - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(V_ACTIVE - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;
    typedef struct packed {
        logic vs;
        logic hs;
        logic de;
        logic win;
        logic last;
    } tap_t;

    state_t         state_q, state_d;
    logic           vs_prev_q, de_prev_q;
    logic [XW-1:0]  x_q, x_d, x_cur;
    logic [YW-1:0]  y_q, y_d, y_cur;
    logic [23:0]    base_q, base_d, base_cur;
    logic [23:0]    addr_q, addr_d, addr_win, dx, dy;
    logic           vs_rise, de_fall, active, win, last;
    tap_t           tap_in, tap_out;
    tap_t           pipe_q [RAM_LAT:0];
    logic [23:0]    rgb_q;
    logic           vs_o_q, hs_o_q, de_o_q, done_q;

    assign vs_rise = bus.vs_in & ~vs_prev_q;
    assign de_fall = ~bus.de_in & de_prev_q;
    // The pixel that coincides with a frame restart already belongs to the
    // new frame, so the restart values are used in the same cycle.
    assign x_cur    = vs_rise ? '0 : x_q;
    assign y_cur    = vs_rise ? '0 : y_q;
    assign base_cur = vs_rise ? {6'd0, bus.offset} : base_q;
    assign active   = (state_q == ACTIVE) || vs_rise;

    assign win  = bus.de_in && (x_cur >= X_LO) && (x_cur < X_HI)
                            && (y_cur >= Y_LO) && (y_cur < Y_HI);
    assign last = win && (x_cur == X_LAST) && (y_cur == Y_LAST);

    assign dx = 24'(x_cur) - 24'(IMG_X0);
    assign dy = 24'(y_cur) - 24'(IMG_Y0);
`ifdef PIXEL_FETCH_ZOOM2X_EN
    assign addr_win = base_cur + (dy >> 1) * 24'(IMG_W) + (dx >> 1);
`else
    assign addr_win = base_cur + dy * 24'(IMG_W) + dx;
`endif

    always_comb begin
        state_d = state_q;
        if (vs_rise) state_d = ACTIVE;

        base_d = base_cur;
        addr_d = (active && win) ? addr_win : addr_q;

        // Saturating counters keep overlong DE / extra lines in the border.
        x_d = x_cur;
        if (bus.de_in) begin
            if (x_cur != X_MAX) x_d = x_cur + XW'(1);
        end else if (de_fall) begin
            x_d = '0;
        end
        y_d = y_cur;
        if (de_fall && !vs_rise && (y_cur != Y_MAX)) y_d = y_cur + YW'(1);

        tap_in = '0;
        if (active) tap_in = '{vs: bus.vs_in, hs: bus.hs_in, de: bus.de_in,
                               win: win, last: last};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_prev_q <= 1'b0;
            de_prev_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            base_q    <= '0;
            addr_q    <= '0;
        end else begin
            vs_prev_q <= bus.vs_in;
            de_prev_q <= bus.de_in;
            x_q       <= x_d;
            y_q       <= y_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
        end
    end

    // Stage k holds the pixel whose address went out k cycles ago; stage
    // RAM_LAT lines up with its q sample.
    assign tap_out = pipe_q[RAM_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= RAM_LAT; i++) pipe_q[i] <= '0;
            rgb_q  <= '0;
            vs_o_q <= 1'b0;
            hs_o_q <= 1'b0;
            de_o_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            pipe_q[0] <= tap_in;
            for (int i = 1; i <= RAM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
            vs_o_q <= tap_out.vs;
            hs_o_q <= tap_out.hs;
            de_o_q <= tap_out.de;
            done_q <= tap_out.last;
            if (!tap_out.de)      rgb_q <= '0;
            else if (tap_out.win) rgb_q <= {3{bus.q}};
            else                  rgb_q <= {3{BORDER}};
        end
    end

    assign bus.parallelAddress = addr_q;
    assign bus.rgb_out         = rgb_q;
    assign bus.vs_out          = vs_o_q;
    assign bus.hs_out          = hs_o_q;
    assign bus.de_out          = de_o_q;
    assign bus.frame_done      = done_q;
endmodule

// File: tb/tb_pixel_fetch.sv
module tb_pixel_fetch;
`ifdef PIXEL_FETCH_ZOOM2X_EN
    localparam int IW = 128;
    localparam int ZS = 1;
`else
    localparam int IW = 256;
    localparam int ZS = 0;
`endif
    localparam int LAT = 4;
    localparam int WE  = IW << ZS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    pixel_fetch_if bus();

    pixel_fetch #(.IMG_W(IW), .IMG_H(IW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Pixel memory with two cycles of latency; returns addr[7:0].
    logic [23:0] r1 = '0, r2 = '0;
    always @(posedge clk) begin
        r1 <= bus.parallelAddress;
        r2 <= r1;
    end
    assign bus.q = r2[7:0];

    typedef struct { int due; logic vs, hs, de, done; logic [23:0] rgb; } oexp_t;
    typedef struct { int due; logic [23:0] addr; } aexp_t;
    oexp_t oq[$];
    aexp_t aq[$];

    int cyc = 0;
    int checks = 0, errors = 0, done_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : mon
        oexp_t e;
        aexp_t a;
        if (!rst) begin
            if (bus.frame_done === 1'b1) done_cnt++;
            while (oq.size() > 0 && oq[0].due == cyc) begin
                e = oq.pop_front();
                chk("de_out", 24'(bus.de_out), 24'(e.de));
                chk("hs_out", 24'(bus.hs_out), 24'(e.hs));
                chk("vs_out", 24'(bus.vs_out), 24'(e.vs));
                chk("rgb_out", bus.rgb_out, e.rgb);
                chk("frame_done", 24'(bus.frame_done), 24'(e.done));
            end
            while (aq.size() > 0 && aq[0].due == cyc) begin
                a = aq.pop_front();
                chk("parallelAddress", bus.parallelAddress, a.addr);
            end
        end
    end

    // Reference raster model.
    logic        m_vsp = 0, m_dep = 0, m_act = 0;
    int          m_x = 0, m_y = 0;
    logic [23:0] m_base = '0, m_addr = '0;

    task automatic mreset();
        m_vsp = 0; m_dep = 0; m_act = 0; m_x = 0; m_y = 0;
        m_base = '0; m_addr = '0;
        oq.delete();
        aq.delete();
    endtask

    task automatic step(input logic vs, input logic hs, input logic de);
        logic rise, fall, win, last;
        int px, py;
        logic [23:0] a;
        oexp_t o;
        aexp_t ae;
        bus.vs_in = vs; bus.hs_in = hs; bus.de_in = de;
        rise = vs && !m_vsp;
        fall = !de && m_dep;
        if (rise) begin
            m_act = 1; m_x = 0; m_y = 0; m_base = {6'd0, bus.offset};
        end
        px = m_x; py = m_y;
        win  = de && px >= 192 && px < 192 + WE && py >= 112 && py < 112 + WE;
        last = win && px == 191 + WE && py == 111 + WE;
        a = m_base;
        if (win) a = m_base + 24'((((py - 112) >> ZS) * IW) + ((px - 192) >> ZS));
        if (m_act && win) m_addr = a;
        o.due  = cyc + LAT;
        o.vs   = m_act && vs;
        o.hs   = m_act && hs;
        o.de   = m_act && de;
        o.done = m_act && last;
        o.rgb  = (m_act && de && win) ? {3{a[7:0]}} : 24'h0;
        oq.push_back(o);
        ae.due = cyc + 1;
        ae.addr = m_addr;
        aq.push_back(ae);
        if (de) begin
            if (m_x < 639) m_x++;
        end else if (fall) begin
            m_x = 0;
        end
        if (fall && !rise && m_y < 479) m_y++;
        m_vsp = vs; m_dep = de;
        @(negedge clk);
    endtask

    function automatic int len_for(input int y);
        if (y >= 112 && y <= 114) return 260;
        if (y == 367)             return 460;
        if (y == 200)             return 700;   // overlong DE: x saturates
        return 3;
    endfunction

    task automatic line(input int len);
        step(0, 1, 0);
        for (int i = 0; i < len; i++) step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
    endtask

    task automatic frame(input int lines, input logic de_on_vs, input int off_line);
        step(1, 0, de_on_vs);
        step(1, 0, de_on_vs);
        step(0, 0, 0);
        step(0, 0, 0);
        for (int y = (de_on_vs ? 1 : 0); y < lines; y++) begin
            if (y == off_line) bus.offset = 18'h00100;
            line(len_for(y));
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bus.vs_in = 0; bus.hs_in = 0; bus.de_in = 0; bus.offset = '0;
        #1;
        chk("rst_addr", bus.parallelAddress, 24'h0);
        chk("rst_rgb", bus.rgb_out, 24'h0);
        chk("rst_de", 24'(bus.de_out), 24'h0);
        chk("rst_done", 24'(bus.frame_done), 24'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;

        // DE before any vs: block stays idle.
        line(250);

        // Frame 1: base 0; offset rewritten mid-frame.
        frame(370, 1'b0, 150);
        repeat (8) step(0, 0, 0);
        chk("done_cnt_f1", 24'(done_cnt), 24'd1);

        // Frame 2: DE together with the vs edge; new base 0x100.
        frame(370, 1'b1, -1);
        repeat (8) step(0, 0, 0);
        chk("done_cnt_f2", 24'(done_cnt), 24'd2);

        // Frame 3: reset in the middle of window line 113.
        step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);
        for (int y = 0; y < 113; y++) line(len_for(y));
        step(0, 1, 0);
        for (int i = 0; i < 220; i++) step(0, 0, 1);
        rst = 1;
        #1;
        chk("mid_rst_addr", bus.parallelAddress, 24'h0);
        chk("mid_rst_rgb", bus.rgb_out, 24'h0);
        chk("mid_rst_de", 24'(bus.de_out), 24'h0);
        chk("mid_rst_hs", 24'(bus.hs_out), 24'h0);
        chk("mid_rst_vs", 24'(bus.vs_out), 24'h0);
        chk("mid_rst_done", 24'(bus.frame_done), 24'h0);
        mreset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;

        // Lines without vs: outputs stay dark.
        for (int i = 0; i < 3; i++) line(260);
        // Next frame resumes output.
        frame(116, 1'b0, -1);
        repeat (8) step(0, 0, 0);
        chk("done_cnt_end", 24'(done_cnt), 24'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
